// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte write/read over a
// simple byte-stream interface, open-drain SDA, no stretching.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    k_idle,
    k_addr,
    k_addr_ack,
    k_rx,
    k_rx_ack,
    k_tx,
    k_tx_ack
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_bit_ctr;
  logic [7:0]             r_shift;
  logic                   r_ack;
  logic [SYNC_STAGES-1:0] r_scl_s;
  logic [SYNC_STAGES-1:0] r_sda_s;
  logic                   r_scl_d;
  logic                   r_sda_d;

  logic w_scl;
  logic w_sda;
  logic w_start;
  logic w_stop;
  logic w_rise;
  logic w_fall;
  logic w_last;

  // Synchronisers idle high to match a released bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s <= '1;
      r_sda_s <= '1;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[SYNC_STAGES-2:0], scl_i};
      r_sda_s <= {r_sda_s[SYNC_STAGES-2:0], sda_i};
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl = r_scl_s[SYNC_STAGES-1];
  assign w_sda = r_sda_s[SYNC_STAGES-1];

  // SCL must be stable high across the SDA edge
  assign w_start = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop  = r_scl_d & w_scl & ~r_sda_d & w_sda;
  assign w_rise  = ~r_scl_d & w_scl;
  assign w_fall  = r_scl_d & ~w_scl;
  assign w_last  = (r_bit_ctr == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= k_idle;
      r_bit_ctr <= 4'd0;
      r_shift   <= 8'd0;
      r_ack     <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (w_start) begin
        r_state   <= k_addr;
        r_bit_ctr <= 4'd0;
        sda_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= k_idle;
        r_bit_ctr <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          k_idle: begin
            r_bit_ctr <= 4'd0;
          end
          k_addr: begin
            if (w_rise && !w_last) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_ctr <= r_bit_ctr + 4'd1;
            end else if (w_fall && w_last) begin
              r_bit_ctr <= 4'd0;
              if (r_shift[7:1] == ADDR) begin
                r_state <= k_addr_ack;
                sda_oe  <= 1'b1;
                busy    <= 1'b1;
              end else begin
                r_state <= k_idle;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
              end
            end
          end
          k_addr_ack: begin
            if (w_fall) begin
              r_bit_ctr <= 4'd0;
              if (r_shift[0]) begin
                r_state <= k_tx;
                tx_req  <= 1'b1;
                r_shift <= tx_data;
                sda_oe  <= ~tx_data[7];
              end else begin
                r_state <= k_rx;
                sda_oe  <= 1'b0;
              end
            end
          end
          k_rx: begin
            if (w_rise && !w_last) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_ctr <= r_bit_ctr + 4'd1;
            end else if (w_fall && w_last) begin
              rx_data   <= r_shift;
              rx_valid  <= 1'b1;
              sda_oe    <= 1'b1;
              r_bit_ctr <= 4'd0;
              r_state   <= k_rx_ack;
            end
          end
          k_rx_ack: begin
            if (w_fall) begin
              sda_oe    <= 1'b0;
              r_bit_ctr <= 4'd0;
              r_state   <= k_rx;
            end
          end
          k_tx: begin
            if (w_rise && !w_last) begin
              r_bit_ctr <= r_bit_ctr + 4'd1;
            end else if (w_fall) begin
              if (w_last) begin
                sda_oe    <= 1'b0;
                r_bit_ctr <= 4'd0;
                r_state   <= k_tx_ack;
              end else if (r_bit_ctr != 4'd0) begin
                r_shift <= {r_shift[6:0], 1'b0};
                sda_oe  <= ~r_shift[6];
              end
            end
          end
          k_tx_ack: begin
            if (w_rise) begin
              r_ack <= w_sda;
            end else if (w_fall) begin
              r_bit_ctr <= 4'd0;
              if (!r_ack) begin
                tx_req  <= 1'b1;
                r_shift <= tx_data;
                sda_oe  <= ~tx_data[7];
                r_state <= k_tx;
              end else begin
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                r_state <= k_idle;
              end
            end
          end
          default: begin
            r_state <= k_idle;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller
// drives the bus; rx/tx bytes are checked against queues.
module tb_i2c_target;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_c;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       busy;

  assign sda_bus = sda_c & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(
    .ADDR       (7'h42),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .busy    (busy)
  );

  function automatic logic [7:0] tx_byte(input int i);
    case (i)
      0:       return 8'h5A;
      1:       return 8'hC3;
      2:       return 8'hA7;
      default: return 8'h00;
    endcase
  endfunction

  int         rx_cnt = 0;
  int         txreq_cnt = 0;
  int         oe_cnt = 0;
  int         clash_cnt = 0;
  logic [7:0] rx_log [64];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt[5:0]] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req) txreq_cnt <= txreq_cnt + 1;
    if (rx_valid && tx_req) clash_cnt <= clash_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    tx_data <= tx_byte(txreq_cnt + (tx_req ? 1 : 0));
  end

  int         n_chk = 0;
  int         n_pass = 0;
  int         rx_rd = 0;
  logic [7:0] exp_rx_q [$];
  logic [7:0] exp_tx_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    qw(); sda_c = 1'b1;
    qw(); scl = 1'b1;
    qw(); sda_c = 1'b0;
    qw(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    qw(); sda_c = 1'b0;
    qw(); scl = 1'b1;
    qw(); sda_c = 1'b1;
    qw();
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    qw(); sda_c = b;
    qw(); scl = 1'b1;
    qw(); r = sda_bus;
    qw(); scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  task automatic check_rx(input string tag);
    while (exp_rx_q.size() > 0) begin
      chk(tag, {24'd0, rx_log[rx_rd[5:0]]}, {24'd0, exp_rx_q.pop_front()});
      rx_rd++;
    end
    chk({tag, "_cnt"}, rx_cnt, rx_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    int         base;

    rst_n = 1'b0;
    scl   = 1'b1;
    sda_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    qw();

    // 1: write two bytes
    i2c_start();
    wbyte(8'h84, ack);
    chk("t1_addr_ack", ack, 0);
    chk("t1_busy", busy, 1);
    exp_rx_q.push_back(8'hA5);
    wbyte(8'hA5, ack);
    chk("t1_ack0", ack, 0);
    exp_rx_q.push_back(8'h3C);
    wbyte(8'h3C, ack);
    chk("t1_ack1", ack, 0);
    i2c_stop();
    chk("t1_busy_stop", busy, 0);
    check_rx("t1_rx");

    // 2: address mismatch
    base = oe_cnt;
    i2c_start();
    wbyte(8'h86, ack);
    chk("t2_addr_nack", ack, 1);
    chk("t2_busy", busy, 0);
    wbyte(8'h55, ack);
    chk("t2_data_nack", ack, 1);
    i2c_stop();
    chk("t2_oe_never", oe_cnt - base, 0);
    check_rx("t2_rx");

    // 3: read two bytes, ACK then NACK
    base = txreq_cnt;
    i2c_start();
    wbyte(8'h85, ack);
    chk("t3_addr_ack", ack, 0);
    chk("t3_busy", busy, 1);
    exp_tx_q.push_back(8'h5A);
    exp_tx_q.push_back(8'hC3);
    rbyte(1'b0, d);
    chk("t3_rd0", d, exp_tx_q.pop_front());
    rbyte(1'b1, d);
    chk("t3_rd1", d, exp_tx_q.pop_front());
    qw();
    chk("t3_oe_rel", sda_oe, 0);
    chk("t3_busy_nack", busy, 0);
    chk("t3_txreq", txreq_cnt - base, 2);
    i2c_stop();

    // 4: write then repeated START into read
    base = txreq_cnt;
    i2c_start();
    wbyte(8'h84, ack);
    chk("t4_addr_ack", ack, 0);
    exp_rx_q.push_back(8'h11);
    wbyte(8'h11, ack);
    chk("t4_data_ack", ack, 0);
    i2c_start();
    chk("t4_busy_rs", busy, 1);
    check_rx("t4_rx");
    wbyte(8'h85, ack);
    chk("t4_raddr_ack", ack, 0);
    exp_tx_q.push_back(8'hA7);
    rbyte(1'b1, d);
    chk("t4_rd", d, exp_tx_q.pop_front());
    chk("t4_txreq", txreq_cnt - base, 1);
    i2c_stop();

    // 5: reset during a driven read bit
    i2c_start();
    wbyte(8'h85, ack);
    chk("t5_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) begin
      i2c_bit(1'b1, r);
      chk("t5_bit", r, 0);
    end
    qw(); sda_c = 1'b1;
    qw(); scl = 1'b1;
    qw();
    chk("t5_oe_pre", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_oe_async", sda_oe, 0);
    chk("t5_busy_rst", busy, 0);
    qw();
    rst_n = 1'b1;
    qw(); scl = 1'b0;
    i2c_stop();
    i2c_start();
    wbyte(8'h84, ack);
    chk("t5_addr_ack2", ack, 0);
    exp_rx_q.push_back(8'h77);
    wbyte(8'h77, ack);
    chk("t5_data_ack", ack, 0);
    i2c_stop();
    check_rx("t5_rx");

    // 6: STOP after three data bits
    i2c_start();
    wbyte(8'h84, ack);
    chk("t6_addr_ack", ack, 0);
    i2c_bit(1'b1, r);
    i2c_bit(1'b0, r);
    i2c_bit(1'b1, r);
    i2c_stop();
    qw();
    chk("t6_oe", sda_oe, 0);
    chk("t6_busy", busy, 0);
    check_rx("t6_rx");

    chk("clash", clash_cnt, 0);
    chk("txreq_total", txreq_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
